// File: rtl/dec_grant_arbiter.sv
// dec_grant_arbiter: 4-requester round-robin arbiter with a registered one-hot grant.
// A request seen in IDLE is granted at the next edge. The grant is held while
// the owner keeps requesting. Every release passes through one IDLE cycle, and
// the priority pointer then moves to the requester after the released owner.
// Optional tenure limit: define ARB_TIMEOUT_EN to compile in a hold counter.
// The counter force-releases a grant after MAX_HOLD cycles and pulses
// hold_expired. Without the macro, hold_expired is constant 0.
module dec_grant_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       hold_expired
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [3:0] gnt_q, gnt_d;
  logic       expired_q, expired_d;

  logic [3:0] req_rot;
  logic [1:0] win_off;
  logic [1:0] winner;
  logic       timeout;

  // Reject tenure limits that do not fit the 4-bit hold counter.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("dec_grant_arbiter: MAX_HOLD must be within 1..15");
  end

  // Rotate the request vector so that bit 0 is the requester at the pointer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = req[ptr_q + 2'(gi)];
  end

  // Find the first requester at or above the pointer, wrapping modulo 4.
  always_comb begin
    win_off = 2'd3;
    if (req_rot[0])      win_off = 2'd0;
    else if (req_rot[1]) win_off = 2'd1;
    else if (req_rot[2]) win_off = 2'd2;
    winner = ptr_q + win_off;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [3:0] hold_cnt_q, hold_cnt_d;

  // The counter is zero on the first GRANT cycle and counts each later GRANT cycle.
  always_comb begin
    hold_cnt_d = 4'd0;
    if (state_q == GRANT) hold_cnt_d = hold_cnt_q + 4'd1;
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) hold_cnt_q <= 4'd0;
    else     hold_cnt_q <= hold_cnt_d;
  end

  assign timeout = (hold_cnt_q == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic. All outputs are taken from registers.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
          vld_d   = 1'b1;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // The owner let go: give up the grant and move priority past it.
          state_d = IDLE;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 2'd1;
        end else if (timeout) begin
          // The tenure limit was reached: force the release and flag it for one cycle.
          state_d   = IDLE;
          vld_d     = 1'b0;
          ptr_d     = idx_q + 2'd1;
          expired_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // 2:4 decode of the next index, enabled by the next valid bit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign gnt_d[gi] = vld_d && (idx_d == 2'(gi));
  end

  // State and output registers. Reset drops any grant at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      vld_q     <= 1'b0;
      gnt_q     <= 4'd0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      gnt_q     <= gnt_d;
      expired_q <= expired_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_idx      = idx_q;
  assign gnt_vld      = vld_q;
  assign hold_expired = expired_q;

endmodule

// File: doc/dec_grant_arbiter.md
DEC_GRANT_ARBITER -- requirements
Module: dec_grant_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, sets the maximum grant tenure in cycles; legal range 1..15.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request lines; bit i set means requester i wants the shared resource.
REQ-005 gnt  output 4  one-hot grant, produced by a 2:4 decode of gnt_idx gated by gnt_vld; all zeros when gnt_vld is 0.
REQ-006 gnt_idx  output 2  index of the current or last granted requester.
REQ-007 gnt_vld  output 1  high while a grant is active; acts as the decoder enable.
REQ-008 hold_expired  output 1  one-cycle pulse when a grant is force-released by timeout.

Function
REQ-009 The FSM SHALL have exactly two states, IDLE and GRANT, with all outputs registered.
REQ-010 In IDLE with req != 0, the block SHALL enter GRANT at the next edge with gnt_idx set to the round-robin winner (one-cycle request-to-grant latency).
REQ-011 Round-robin winner: the first set bit of req, searching upward modulo 4 from ptr, where ptr is a 2-bit priority pointer.
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with gnt_vld = 0 and ptr unchanged.
REQ-013 In GRANT, the grant SHALL be held while req[gnt_idx] = 1; no other requester preempts it.
REQ-014 In GRANT, when req[gnt_idx] = 0, the block SHALL return to IDLE at that edge, clear gnt_vld, and set ptr to gnt_idx+1 (mod 4).
REQ-015 After any release, at least one IDLE cycle with gnt = 0 SHALL occur before the next grant, so back-to-back grants are never contiguous.
REQ-016 gnt SHALL never have more than one bit set, and no bit SHALL be set while gnt_vld = 0.
REQ-017 gnt_idx SHALL retain its value in IDLE.
REQ-018 Simultaneous requests in IDLE: only the round-robin winner is granted; losers keep waiting without any loss of state.
REQ-019 A requester that drops req in the same cycle it is granted SHALL keep the grant for that one cycle and then release per REQ-014.

Reset
REQ-020 While rst = 1 at a clock edge: state = IDLE, ptr = 0, gnt_idx = 0, gnt_vld = 0, gnt = 4'b0000, hold_expired = 0, and hold counter = 0.
REQ-021 Reset asserted during GRANT SHALL drop the grant at that same edge, regardless of req.
REQ-022 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN compiles in the tenure-limit feature.
REQ-024 With ARB_TIMEOUT_EN defined, a 4-bit hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle.
REQ-025 With ARB_TIMEOUT_EN defined, if the counter equals MAX_HOLD-1 while req[gnt_idx] = 1, the block SHALL return to IDLE at the next edge, advance ptr as in REQ-014, and pulse hold_expired for exactly one cycle.
REQ-026 With ARB_TIMEOUT_EN defined, a timed-out requester that is still requesting competes normally in the following arbitration.
REQ-027 Without ARB_TIMEOUT_EN, no hold counter SHALL exist, hold_expired SHALL be tied to 0, and the grant SHALL be held indefinitely per REQ-013.

Verification
REQ-028 Reset, then req = 4'b1111: gnt = 0001 one cycle later. Drop req[0]: one idle cycle, then gnt = 0010. Continuing the sequence, gnt walks 0100, then 1000, then 0001.
REQ-029 Single requester req = 4'b0100 held 20 cycles, macro off: gnt = 0100 for 20 cycles and hold_expired always 0. Drop req: gnt = 0000 next cycle.
REQ-030 Macro on, MAX_HOLD = 4, req = 4'b0011 held: gnt = 0001 for exactly 4 cycles, then a hold_expired pulse with gnt = 0000, then gnt = 0010 for 4 cycles.
REQ-031 rst asserted mid-grant (gnt = 1000): next edge gnt = 0000 and gnt_idx = 0. Release rst with req = 1001: gnt = 0001.
REQ-032 Apply random req for 10k cycles: gnt is always one-hot or zero, and every persistently asserted request is granted within 4 grant tenures.
